mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified RAM port between instruction-fetch and data
//  load/store requesters. Sits between the request unit / caches and RAM.
//  Data requests take priority. A starvation counter forces an instruction
//  grant after FAIR_MAX back-to-back data grants. A watchdog aborts RAM
//  accesses that never complete.
// PARAMETERS
//  ADDR_W    32   address width, both requesters and RAM
//  DATA_W    32   data width
//  FAIR_MAX  4    consecutive data grants allowed while iREN pending (>=1)
//  TIMEOUT   64   cycles in an access state without ram_rdy before abort (>=2)
// PORTS
//  CLK        in   1       clock, all state updates on rising edge
//  RST        in   1       synchronous reset, active-high
//  iREN       in   1       instruction read request; held until ihit
//  iaddr      in   ADDR_W  instruction address
//  dREN       in   1       data read request; held until dhit
//  dWEN       in   1       data write request; held until dhit
//  daddr      in   ADDR_W  data address
//  dstore     in   DATA_W  write data
//  ihit       out  1       1-cycle pulse: instruction access done, iload valid
//  dhit       out  1       1-cycle pulse: data access done, dload valid (reads)
//  iload      out  DATA_W  fetched instruction (= ram_load while ihit)
//  dload      out  DATA_W  loaded data (= ram_load while dhit)
//  ramREN     out  1       RAM read strobe
//  ramWEN     out  1       RAM write strobe
//  ramaddr    out  ADDR_W  RAM address (latched at grant)
//  ramstore   out  DATA_W  RAM write data (latched at grant)
//  ram_load   in   DATA_W  RAM read data, valid with ram_rdy
//  ram_rdy    in   1       RAM completes current access this cycle
//  bus_err    out  1       sticky: a watchdog abort occurred; cleared only by RST
// BEHAVIOUR
//  - Reset: state IDLE; fair_cnt=0; wd_cnt=0; ramaddr=0; ramstore=0; bus_err=0.
//    All strobes and hits are 0. RST mid-access drops the access at that edge.
//  - States: IDLE, IACC, DACC. ramREN=1 in IACC and in DACC-read.
//    ramWEN=1 in DACC-write. Both strobes are 0 in IDLE.
//  - IDLE grant (registered; the access starts the next cycle):
//    * If (dREN|dWEN) and not (iREN and fair_cnt==FAIR_MAX): go to DACC,
//      latch daddr/dstore and the op type, fair_cnt += iREN ? 1 : 0.
//    * Else if iREN: go to IACC, latch iaddr, fair_cnt=0.
//    * Else stay in IDLE and hold fair_cnt.
//  - dREN&dWEN both high: treated as write. The read is ignored.
//  - Access states: wd_cnt increments each cycle (cleared on entry).
//    * ram_rdy=1: pulse ihit (IACC) or dhit (DACC) combinationally that cycle,
//      then go to IDLE. There is always 1 IDLE bubble between accesses.
//    * wd_cnt==TIMEOUT-1 and !ram_rdy: go to IDLE, set bus_err, no hit.
//      The request is still held, so it is re-arbitrated (retry).
//    * ram_rdy and timeout in the same cycle: completion wins, no error.
//  - Latency: request seen in IDLE at cycle t, strobe at t+1, hit in the same
//    cycle as ram_rdy, earliest t+1. Latched addr/data ignore input changes
//    during an access.
//  - iload/dload are 0 when their hit is low.
//  - fair_cnt saturates at FAIR_MAX.
// TESTING
//  1 Single fetch: iREN=1, iaddr=0x100, ram_rdy 2 cycles after strobe,
//    ram_load=0x8C010004 -> ramREN,ramaddr=0x100; ihit 1 cycle with
//    iload=0x8C010004.
//  2 Contention: iREN & dREN together from IDLE -> DACC first. IACC is granted
//    after the DACC hit and 1 bubble.
//  3 Starvation, FAIR_MAX=4: dREN held continuously, iREN held -> 4 data grants,
//    then the 5th grant is IACC; fair_cnt returns to 0.
//  4 Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1 with latched
//    values, ramREN=0; dhit on ram_rdy. Changing daddr mid-access does not
//    change ramaddr.
//  5 Timeout, TIMEOUT=8: ram_rdy held 0 -> after 8 access cycles, back to IDLE,
//    bus_err=1 and sticky, no hit. Re-grant follows. ram_rdy on the 8th cycle
//    -> hit, bus_err stays 0.
//  6 RST asserted mid-DACC -> next cycle all outputs 0, state IDLE; the held
//    request is granted afresh after RST deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one unified RAM port between the instruction-fetch requester and
//   the data load/store requester. Data requests win by default. A fairness
//   counter forces an instruction grant after FAIR_MAX back-to-back data
//   grants taken while a fetch was waiting. A watchdog aborts any RAM access
//   that does not complete within TIMEOUT cycles and raises a sticky bus_err.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         instruction read request (held until ihit) + address
//   dREN, dWEN          data read / write request (held until dhit)
//   daddr, dstore       data address and write data
//   ihit, iload         fetch done pulse and fetched word (0 when ihit low)
//   dhit, dload         data done pulse and loaded word (0 when dhit low)
//   ramREN, ramWEN      RAM read / write strobes
//   ramaddr, ramstore   RAM address / write data, latched at grant
//   ram_load, ram_rdy   RAM read data and access-complete flag
//   bus_err             sticky watchdog-abort flag, cleared only by RST
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_rdy,
  output logic              bus_err
);

  localparam int FW = $clog2(FAIR_MAX + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FAIR_TOP = FW'(FAIR_MAX);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IACC = 2'd1,
    ST_DACC = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [FW-1:0]     fair_cnt_q, fair_cnt_d;
  logic [WW-1:0]     wd_cnt_q,   wd_cnt_d;
  logic [ADDR_W-1:0] ramaddr_q,  ramaddr_d;
  logic [DATA_W-1:0] ramstore_q, ramstore_d;
  logic              wr_q,       wr_d;
  logic              bus_err_q,  bus_err_d;

  logic d_req_s;
  logic starve_s;

  // State register and latched access attributes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      fair_cnt_q <= '0;
      wd_cnt_q   <= '0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      wr_q       <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fair_cnt_q <= fair_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      wr_q       <= wr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Grant decision, watchdog and completion handling.
  always_comb begin
    state_d    = state_q;
    fair_cnt_d = fair_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    wr_d       = wr_q;
    bus_err_d  = bus_err_q;

    d_req_s  = dREN | dWEN;
    // A fetch that has watched FAIR_MAX data grants go by now takes the port.
    starve_s = iREN && (fair_cnt_q == FAIR_TOP);

    case (state_q)
      ST_IDLE: begin
        if (d_req_s && !starve_s) begin
          state_d    = ST_DACC;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          // A simultaneous read+write is performed as a write.
          wr_d       = dWEN;
          wd_cnt_d   = '0;
          if (iREN && (fair_cnt_q != FAIR_TOP)) begin
            fair_cnt_d = fair_cnt_q + FW'(1);
          end else begin
            fair_cnt_d = fair_cnt_q;
          end
        end else if (iREN) begin
          state_d    = ST_IACC;
          ramaddr_d  = iaddr;
          fair_cnt_d = '0;
          wd_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IACC, ST_DACC: begin
        // Completion has priority over the watchdog in the same cycle.
        if (ram_rdy) begin
          state_d = ST_IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes come straight from the state register; hits follow ram_rdy.
  always_comb begin
    ramREN   = (state_q == ST_IACC) || ((state_q == ST_DACC) && !wr_q);
    ramWEN   = (state_q == ST_DACC) && wr_q;
    ihit     = (state_q == ST_IACC) && ram_rdy;
    dhit     = (state_q == ST_DACC) && ram_rdy;
    iload    = ihit ? ram_load : '0;
    dload    = dhit ? ram_load : '0;
    ramaddr  = ramaddr_q;
    ramstore = ramstore_q;
    bus_err  = bus_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int FAIR = 4;
  localparam int TMO  = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_rdy;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        ihit, dhit, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_MAX(FAIR), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ram_load(ram_load), .ram_rdy(ram_rdy), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: who holds the RAM port (0 nobody, 1 fetch, 2 data)
  int          m_owner, m_fair, m_age;
  bit          m_wr, m_err;
  logic [31:0] m_addr, m_store;
  logic        e_ren, e_wen, e_ihit, e_dhit;
  logic [31:0] e_iload, e_dload;

  task automatic model_reset();
    m_owner = 0; m_fair = 0; m_age = 0; m_wr = 0; m_err = 0;
    m_addr = 32'h0; m_store = 32'h0;
  endtask

  task automatic model_eval();
    e_ren   = (m_owner == 1) || (m_owner == 2 && !m_wr);
    e_wen   = (m_owner == 2) && m_wr;
    e_ihit  = (m_owner == 1) && ram_rdy;
    e_dhit  = (m_owner == 2) && ram_rdy;
    e_iload = e_ihit ? ram_load : 32'h0;
    e_dload = e_dhit ? ram_load : 32'h0;
  endtask

  task automatic model_step();
    if (RST) begin
      model_reset();
    end else if (m_owner == 0) begin
      if ((dREN || dWEN) && !(iREN && m_fair == FAIR)) begin
        m_owner = 2; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_age = 0;
        if (iREN) m_fair = (m_fair + 1 > FAIR) ? FAIR : m_fair + 1;
      end else if (iREN) begin
        m_owner = 1; m_addr = iaddr; m_fair = 0; m_age = 0;
      end
    end else begin
      if (ram_rdy) m_owner = 0;
      else if (m_age == TMO - 1) begin m_owner = 0; m_err = 1; end
      else m_age++;
    end
  endtask

  task automatic check_model();
    chk("m_ramREN",   ramREN,   e_ren);
    chk("m_ramWEN",   ramWEN,   e_wen);
    chk("m_ihit",     ihit,     e_ihit);
    chk("m_dhit",     dhit,     e_dhit);
    chk("m_iload",    iload,    e_iload);
    chk("m_dload",    dload,    e_dload);
    chk("m_ramaddr",  ramaddr,  m_addr);
    chk("m_ramstore", ramstore, m_store);
    chk("m_bus_err",  bus_err,  m_err);
  endtask

  logic        obs_ren, obs_wen, obs_ihit, obs_dhit, obs_err;
  logic [31:0] obs_addr;

  // one clock: compare at negedge, advance model at posedge, return at posedge+1
  task automatic tick();
    @(negedge CLK);
    model_eval();
    check_model();
    obs_ren = ramREN; obs_wen = ramWEN; obs_ihit = ihit; obs_dhit = dhit;
    obs_err = bus_err; obs_addr = ramaddr;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  typedef struct {
    logic rst, iren; logic [31:0] iaddr; logic dren, dwen; logic [31:0] daddr, dstore;
    logic rdy; logic [31:0] load;
    logic e_ren, e_wen; logic [31:0] e_addr, e_store; logic e_ihit, e_dhit;
    logic [31:0] e_iload, e_dload; logic e_err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int first_d, first_i, n_d, n_i, acc, hit_at;
    int rounds [2];
    bit any_hit;
    int rdy_pct;

    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_rdy = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ram_load = 32'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    model_reset();
    #1;

    //          rst  iren iaddr       dren dwen daddr       dstore        rdy  load
    //          ren  wen  addr        store         ihit dhit iload         dload         err
    tbl[0]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,
                1'b0,1'b0,32'h0,      32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[1]  = '{1'b0,1'b1,32'h100,    1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,
                1'b0,1'b0,32'h0,      32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[2]  = '{1'b0,1'b1,32'h100,    1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,
                1'b1,1'b0,32'h100,    32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[3]  = '{1'b0,1'b1,32'h104,    1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,
                1'b1,1'b0,32'h100,    32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[4]  = '{1'b0,1'b1,32'h104,    1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h8C010004,
                1'b1,1'b0,32'h100,    32'h0,        1'b1,1'b0,32'h8C010004, 32'h0,        1'b0};
    tbl[5]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h8C010004,
                1'b0,1'b0,32'h100,    32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[6]  = '{1'b0,1'b0,32'h0,      1'b0,1'b1,32'h200,    32'hDEADBEEF, 1'b0,32'h0,
                1'b0,1'b0,32'h100,    32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[7]  = '{1'b0,1'b0,32'h0,      1'b0,1'b1,32'h300,    32'hDEADBEEF, 1'b0,32'h0,
                1'b0,1'b1,32'h200,    32'hDEADBEEF, 1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[8]  = '{1'b0,1'b0,32'h0,      1'b0,1'b1,32'h300,    32'h11111111, 1'b1,32'h55,
                1'b0,1'b1,32'h200,    32'hDEADBEEF, 1'b0,1'b1,32'h0,        32'h55,       1'b0};
    tbl[9]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h55,
                1'b0,1'b0,32'h200,    32'hDEADBEEF, 1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[10] = '{1'b0,1'b0,32'h0,      1'b1,1'b0,32'h44,     32'hA5A5A5A5, 1'b1,32'h99,
                1'b0,1'b0,32'h200,    32'hDEADBEEF, 1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[11] = '{1'b0,1'b0,32'h0,      1'b1,1'b0,32'h44,     32'hA5A5A5A5, 1'b1,32'hCAFEF00D,
                1'b1,1'b0,32'h44,     32'hA5A5A5A5, 1'b0,1'b1,32'h0,        32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,
                1'b0,1'b0,32'h44,     32'hA5A5A5A5, 1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[13] = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h48,     32'h12345678, 1'b0,32'h0,
                1'b0,1'b0,32'h44,     32'hA5A5A5A5, 1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[14] = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h48,     32'h12345678, 1'b0,32'h0,
                1'b0,1'b1,32'h48,     32'h12345678, 1'b0,1'b0,32'h0,        32'h0,        1'b0};
    tbl[15] = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h48,     32'h12345678, 1'b1,32'h77,
                1'b0,1'b1,32'h48,     32'h12345678, 1'b0,1'b1,32'h0,        32'h77,       1'b0};
    tbl[16] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,
                1'b0,1'b0,32'h48,     32'h12345678, 1'b0,1'b0,32'h0,        32'h0,        1'b0};

    // ---- table: reset state, single fetch, write, read, read+write ----
    for (int i = 0; i < 17; i++) begin
      RST = tbl[i].rst; iREN = tbl[i].iren; iaddr = tbl[i].iaddr;
      dREN = tbl[i].dren; dWEN = tbl[i].dwen; daddr = tbl[i].daddr; dstore = tbl[i].dstore;
      ram_rdy = tbl[i].rdy; ram_load = tbl[i].load;
      @(negedge CLK);
      model_eval();
      check_model();
      chk($sformatf("t%0d_ramREN", i),   ramREN,   tbl[i].e_ren);
      chk($sformatf("t%0d_ramWEN", i),   ramWEN,   tbl[i].e_wen);
      chk($sformatf("t%0d_ramaddr", i),  ramaddr,  tbl[i].e_addr);
      chk($sformatf("t%0d_ramstore", i), ramstore, tbl[i].e_store);
      chk($sformatf("t%0d_ihit", i),     ihit,     tbl[i].e_ihit);
      chk($sformatf("t%0d_dhit", i),     dhit,     tbl[i].e_dhit);
      chk($sformatf("t%0d_iload", i),    iload,    tbl[i].e_iload);
      chk($sformatf("t%0d_dload", i),    dload,    tbl[i].e_dload);
      chk($sformatf("t%0d_bus_err", i),  bus_err,  tbl[i].e_err);
      @(posedge CLK);
      model_step();
      #1;
    end

    // ---- contention: data first, fetch after one bubble ----
    iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h400;
    ram_rdy = 1'b1; ram_load = 32'h1234;
    first_d = -1; first_i = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (obs_dhit) begin if (first_d < 0) first_d = c; dREN = 1'b0; end
      if (obs_ihit) begin if (first_i < 0) first_i = c; iREN = 1'b0; end
    end
    chk("contention_dhit_cycle", first_d, 1);
    chk("contention_ihit_cycle", first_i, 3);

    // ---- starvation: FAIR data grants, then one fetch, twice ----
    iREN = 1'b1; dREN = 1'b1; ram_rdy = 1'b1;
    n_d = 0; n_i = 0; rounds[0] = -1; rounds[1] = -1;
    for (int c = 0; c < 60 && n_i < 2; c++) begin
      tick();
      if (obs_dhit) n_d++;
      if (obs_ihit) begin rounds[n_i] = n_d; n_d = 0; n_i++; end
    end
    chk("starve_fetches_seen", n_i, 2);
    chk("starve_round0_data", rounds[0], FAIR);
    chk("starve_round1_data", rounds[1], FAIR);
    iREN = 1'b0; dREN = 1'b0; ram_rdy = 1'b0;
    tick();

    // ---- ram_rdy on the last watchdog cycle completes without error ----
    dREN = 1'b1; daddr = 32'h600; ram_rdy = 1'b0;
    tick();
    hit_at = -1;
    for (int k = 1; k <= TMO; k++) begin
      ram_rdy = (k == TMO);
      tick();
      if (obs_dhit && hit_at < 0) hit_at = k;
    end
    dREN = 1'b0; ram_rdy = 1'b0;
    tick();
    chk("late_rdy_hit_cycle", hit_at, TMO);
    chk("late_rdy_no_err", obs_err, 1'b0);

    // ---- watchdog abort, sticky error, retry ----
    dREN = 1'b1; daddr = 32'h640; ram_rdy = 1'b0;
    tick();
    acc = 0; any_hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (obs_dhit) any_hit = 1'b1;
      if (!obs_ren) break;
      acc++;
    end
    chk("timeout_access_cycles", acc, TMO);
    chk("timeout_err_set", obs_err, 1'b1);
    chk("timeout_no_hit", any_hit, 1'b0);
    tick();
    chk("timeout_regrant", obs_ren, 1'b1);
    ram_rdy = 1'b1;
    tick();
    chk("retry_hit", obs_dhit, 1'b1);
    dREN = 1'b0; ram_rdy = 1'b0;
    tick();
    chk("err_sticky", obs_err, 1'b1);

    // ---- reset mid data access ----
    dREN = 1'b1; daddr = 32'h700;
    tick();
    tick();
    chk("rst_pre_access", obs_ren, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("rst_ren_zero", obs_ren, 1'b0);
    chk("rst_wen_zero", obs_wen, 1'b0);
    chk("rst_err_clear", obs_err, 1'b0);
    chk("rst_addr_zero", obs_addr, 32'h0);
    tick();
    chk("rst_fresh_grant", obs_ren, 1'b1);
    chk("rst_fresh_addr", obs_addr, 32'h700);
    ram_rdy = 1'b1;
    tick();
    dREN = 1'b0; ram_rdy = 1'b0;
    tick();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = (c < 1500) ? 50 : 9;
      ram_rdy  = ($urandom_range(99) < rdy_pct);
      ram_load = $urandom;
      RST      = ($urandom_range(199) == 0);
      if ($urandom_range(7) == 0) daddr = $urandom;
      if ($urandom_range(7) == 0) iaddr = $urandom;
      if ($urandom_range(7) == 0) dstore = $urandom;
      tick();
      if (e_ihit) iREN = 1'b0;
      if (e_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
      if (!iREN && $urandom_range(2) == 0) begin iREN = 1'b1; iaddr = $urandom; end
      if (!dREN && !dWEN && $urandom_range(2) == 0) begin
        case ($urandom_range(2))
          0: begin dREN = 1'b1; dWEN = 1'b0; end
          1: begin dREN = 1'b0; dWEN = 1'b1; end
          default: begin dREN = 1'b1; dWEN = 1'b1; end
        endcase
        daddr = $urandom; dstore = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
